// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: mode encoding,
// fixed instruction-field positions and a legality helper for the mode field.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_DP8    = 3'b000,
    IMM_MEM12  = 3'b001,
    IMM_BR     = 3'b010,
    IMM_DPROT  = 3'b011,
    IMM_MEMSGN = 3'b100
  } imm_src_e;

  // Rotate amount lives in instr[11:8]; the offset sign (U) bit in instr[23].
  localparam int ROT_FIELD_LSB = 8;
  localparam int U_BIT         = 23;

  // Encodings above MEMSGN are reserved and flagged as illegal.
  function automatic logic mode_is_legal(input logic [2:0] src);
    return (src <= 3'b100);
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for the immediate generator: request side (decode) and
// result side (execute) plus the pipeline squash. The DUT uses the slave view.
interface imm_ext_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        imm_src;
  logic [IMM_W-1:0]  instr;
  logic              c_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_imm;
  logic              c_out;
  logic              illegal;

  modport master (
    output flush, in_valid, imm_src, instr, c_in, out_ready,
    input  in_ready, out_valid, ext_imm, c_out, illegal
  );

  modport slave (
    input  flush, in_valid, imm_src, instr, c_in, out_ready,
    output in_ready, out_valid, ext_imm, c_out, illegal
  );
endinterface

// File: rtl/imm_rot_core.sv
// Purely combinational immediate datapath: turns a decoded mode, rotate field,
// instruction field and incoming carry into the extended immediate, shifter
// carry-out and illegal flag. No state; usable standalone.
module imm_rot_core
  import imm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24
) (
  input  imm_src_e          mode,
  input  logic              legal,
  input  logic [3:0]        rot,
  input  logic [IMM_W-1:0]  instr,
  input  logic              c_in,
  output logic [DATA_W-1:0] ext_imm,
  output logic              c_out,
  output logic              illegal
);

  logic [DATA_W-1:0]   dp8_zx;
  logic [DATA_W-1:0]   mem12_zx;
  logic [DATA_W-1:0]   br_sx;
  logic [DATA_W-1:0]   br_imm;
  logic [2*DATA_W-1:0] rot_pair;
  logic [DATA_W-1:0]   rot_imm;
  logic [DATA_W-1:0]   memsgn_imm;
  logic                u_bit;

  assign dp8_zx   = DATA_W'(instr[7:0]);
  assign mem12_zx = DATA_W'(instr[11:0]);

  // Sign-extend the whole branch field bit by bit; the top bit fans out.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_br_sx
      if (gi < IMM_W) begin : g_field
        assign br_sx[gi] = instr[gi];
      end else begin : g_sign
        assign br_sx[gi] = instr[IMM_W-1];
      end
    end
  endgenerate

  // Width is at least IMM_W+2, so the word shift never drops significant bits.
  assign br_imm = br_sx << 2;

  // Rotate right by twice the 4-bit field using a doubled word and a shift.
  assign rot_pair = {dp8_zx, dp8_zx} >> {rot, 1'b0};
  assign rot_imm  = rot_pair[DATA_W-1:0];

  // Narrow instruction fields have no U bit; treat the offset as positive.
  generate
    if (IMM_W > U_BIT) begin : g_ubit
      assign u_bit = instr[U_BIT];
    end else begin : g_no_ubit
      assign u_bit = 1'b1;
    end
  endgenerate

  // Negation is modulo 2^DATA_W, so a zero offset stays zero.
  assign memsgn_imm = u_bit ? mem12_zx : (-mem12_zx);

  // Mode select; only a non-zero rotate replaces the incoming carry.
  always_comb begin
    ext_imm = '0;
    c_out   = c_in;
    illegal = !legal;
    if (legal) begin
      case (mode)
        IMM_DP8:    ext_imm = dp8_zx;
        IMM_MEM12:  ext_imm = mem12_zx;
        IMM_BR:     ext_imm = br_imm;
        IMM_DPROT: begin
          ext_imm = rot_imm;
          if (rot != 4'd0) c_out = rot_imm[DATA_W-1];
        end
        IMM_MEMSGN: ext_imm = memsgn_imm;
        default:    ext_imm = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage immediate generator between decode and execute. Stage 1 captures
// the request and decodes mode/rotate; stage 2 registers the computed result.
// Valid/ready on both sides, with a synchronous flush that empties both stages.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_ext_pipe_if.slave bus
);

  logic              s1_valid_reg;
  imm_src_e          s1_mode_reg;
  logic              s1_legal_reg;
  logic [3:0]        s1_rot_reg;
  logic [IMM_W-1:0]  s1_instr_reg;
  logic              s1_c_reg;

  logic              out_valid_reg;
  logic [DATA_W-1:0] ext_imm_reg;
  logic              c_out_reg;
  logic              illegal_reg;

  logic              s2_adv;
  logic              s1_adv;
  logic              legal_next;
  imm_src_e          mode_next;

  logic [DATA_W-1:0] core_imm;
  logic              core_c;
  logic              core_ill;

  // Stage 2 moves when its slot is empty or being drained; stage 1 follows it
  // or refills when empty. in_ready therefore never looks at in_valid.
  assign s2_adv       = !out_valid_reg || bus.out_ready;
  assign s1_adv       = s2_adv || !s1_valid_reg;
  assign bus.in_ready = s1_adv;

  // Reserved encodings are carried as a cleared legal bit with a harmless mode.
  assign legal_next = mode_is_legal(bus.imm_src);
  assign mode_next  = legal_next ? imm_src_e'(bus.imm_src) : IMM_DP8;

  // Stage 1: capture and decode the request when the stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= IMM_DP8;
      s1_legal_reg <= 1'b1;
      s1_rot_reg   <= '0;
      s1_instr_reg <= '0;
      s1_c_reg     <= 1'b0;
    end else if (bus.flush) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_reg  <= mode_next;
        s1_legal_reg <= legal_next;
        s1_rot_reg   <= bus.instr[ROT_FIELD_LSB +: 4];
        s1_instr_reg <= bus.instr;
        s1_c_reg     <= bus.c_in;
      end
    end
  end

  imm_rot_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .mode    (s1_mode_reg),
    .legal   (s1_legal_reg),
    .rot     (s1_rot_reg),
    .instr   (s1_instr_reg),
    .c_in    (s1_c_reg),
    .ext_imm (core_imm),
    .c_out   (core_c),
    .illegal (core_ill)
  );

  // Stage 2: register the result; held unchanged while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      ext_imm_reg   <= '0;
      c_out_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_reg <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        ext_imm_reg <= core_imm;
        c_out_reg   <= core_c;
        illegal_reg <= core_ill;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.ext_imm   = ext_imm_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a 32-bit and a 64-bit instance share one stimulus
// stream. A behavioural model computes expected results from the mode rules.
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.DATA_W(32), .IMM_W(24)) b32 ();
  imm_ext_pipe_if #(.DATA_W(64), .IMM_W(24)) b64 ();

  imm_ext_pipe #(.DATA_W(32), .IMM_W(24)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_ext_pipe #(.DATA_W(64), .IMM_W(24)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  assign b64.flush     = b32.flush;
  assign b64.in_valid  = b32.in_valid;
  assign b64.imm_src   = b32.imm_src;
  assign b64.instr     = b32.instr;
  assign b64.c_in      = b32.c_in;
  assign b64.out_ready = b32.out_ready;

  // {illegal, c_out, 64-bit immediate}
  logic [65:0] exp32[$], exp64[$], got32[$], got64[$];

  // Reference: plain arithmetic on wide integers, truncated to w bits.
  function automatic logic [65:0] model(input int w, input logic [2:0] src,
                                        input logic [23:0] ins, input logic c);
    logic [127:0] mask, v, r;
    logic co, ill;
    int amt;
    longint sv;
    mask = (128'd1 << w) - 128'd1;
    r = '0; co = c; ill = 1'b0;
    case (src)
      3'd0: r = 128'(ins[7:0]);
      3'd1: r = 128'(ins[11:0]);
      3'd2: begin
        sv = longint'(ins);
        if (ins[23]) sv = sv - 64'sd16777216;
        sv = sv * 4;
        r = {{64{sv[63]}}, sv} & mask;
      end
      3'd3: begin
        v = 128'(ins[7:0]);
        amt = 2 * int'(ins[11:8]);
        r = ((v >> amt) | (v << (w - amt))) & mask;
        if (amt != 0) co = r[w-1];
      end
      3'd4: begin
        v = 128'(ins[11:0]);
        r = ins[23] ? v : (((128'd1 << w) - v) & mask);
      end
      default: ill = 1'b1;
    endcase
    return {ill, co, r[63:0]};
  endfunction

  // Record every handshake seen before the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b32.out_valid && b32.out_ready)
        got32.push_back({b32.illegal, b32.c_out, 32'h0, b32.ext_imm});
      if (b64.out_valid && b64.out_ready)
        got64.push_back({b64.illegal, b64.c_out, b64.ext_imm});
      if (b32.in_valid && b32.in_ready && !b32.flush)
        exp32.push_back(model(32, b32.imm_src, b32.instr, b32.c_in));
      if (b64.in_valid && b64.in_ready && !b64.flush)
        exp64.push_back(model(64, b64.imm_src, b64.instr, b64.c_in));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp32.delete(); exp64.delete(); got32.delete(); got64.delete();
  endtask

  task automatic test_reset();
    b32.flush = 0; b32.in_valid = 0; b32.imm_src = 0; b32.instr = 0;
    b32.c_in = 0; b32.out_ready = 1;
    #1;
    total++;
    if (b32.out_valid !== 1'b0 || b32.ext_imm !== 32'h0 || b32.c_out !== 1'b0 || b32.illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset32: got v=%b imm=%h c=%b ill=%b want all 0", b32.out_valid, b32.ext_imm, b32.c_out, b32.illegal);
    end
    total++;
    if (b64.out_valid !== 1'b0 || b64.ext_imm !== 64'h0 || b64.illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset64: got v=%b imm=%h ill=%b want all 0", b64.out_valid, b64.ext_imm, b64.illegal);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", b32.in_ready, b32.out_valid);
    end
    $display("reset: released, in_ready=%b", b32.in_ready);
  endtask

  task automatic test_modes();
    logic [2:0]  d_src[12] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd7, 3'd2};
    logic [23:0] d_ins[12] = '{24'h0000AB, 24'h000FFF, 24'h800001, 24'h7FFFFF, 24'h0004FF, 24'h0000FF,
                               24'h000F01, 24'h800010, 24'h000010, 24'h000000, 24'h123456, 24'h800000};
    logic        d_c[12]   = '{0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0};
    logic [31:0] d_e32[12] = '{32'h000000AB, 32'h00000FFF, 32'hFE000004, 32'h01FFFFFC, 32'hFF000000, 32'h000000FF,
                               32'h00000004, 32'h00000010, 32'hFFFFFFF0, 32'h0, 32'h0, 32'hFE000000};
    logic [63:0] d_e64[12] = '{64'hAB, 64'hFFF, 64'hFFFFFFFFFE000004, 64'h01FFFFFC, 64'hFF00000000000000, 64'hFF,
                               64'h400000000, 64'h10, 64'hFFFFFFFFFFFFFFF0, 64'h0, 64'h0, 64'hFFFFFFFFFE000000};
    logic        d_co[12]  = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0};
    logic        d_ill[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    clear_q();
    b32.out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      b32.in_valid = 1; b32.imm_src = d_src[i]; b32.instr = d_ins[i]; b32.c_in = d_c[i];
      @(negedge clk);
      total++;
      if (b32.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL modes_in_ready[%0d]: got %b want 1", i, b32.in_ready);
      end
      tick();
    end
    b32.in_valid = 0;
    tick();
    total++;
    if (b32.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL modes_last_valid: got %b want 1", b32.out_valid);
    end
    tick();
    total++;
    if (got32.size() != 12 || got64.size() != 12 || b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL modes_count: got n32=%0d n64=%0d valid=%b want 12/12/0", got32.size(), got64.size(), b32.out_valid);
    end
    for (int i = 0; i < 12 && i < got32.size() && i < got64.size(); i++) begin
      total++;
      if (got32[i][31:0] !== d_e32[i] || got32[i][64] !== d_co[i] || got32[i][65] !== d_ill[i]) begin
        bad++;
        $display("FAIL modes32[%0d]: got imm=%h c=%b ill=%b want imm=%h c=%b ill=%b", i,
                 got32[i][31:0], got32[i][64], got32[i][65], d_e32[i], d_co[i], d_ill[i]);
      end
      total++;
      if (got64[i][63:0] !== d_e64[i] || got64[i][64] !== d_co[i] || got64[i][65] !== d_ill[i]) begin
        bad++;
        $display("FAIL modes64[%0d]: got imm=%h c=%b ill=%b want imm=%h c=%b ill=%b", i,
                 got64[i][63:0], got64[i][64], got64[i][65], d_e64[i], d_co[i], d_ill[i]);
      end
      $display("mode %0d src=%0d instr=%h -> %h / %h", i, d_src[i], d_ins[i], got32[i][31:0], got64[i][63:0]);
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int i = 0; i < 300; i++) begin
      b32.in_valid  = ($urandom_range(0, 9) < 7);
      b32.imm_src   = 3'($urandom_range(0, 7));
      b32.instr     = 24'($urandom);
      b32.c_in      = 1'($urandom);
      b32.out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    b32.in_valid = 0; b32.out_ready = 1;
    repeat (4) tick();
    total++;
    if (got32.size() != exp32.size() || got64.size() != exp64.size()) begin
      bad++;
      $display("FAIL random_count: got %0d/%0d want %0d/%0d", got32.size(), got64.size(), exp32.size(), exp64.size());
    end
    for (int i = 0; i < got32.size() && i < exp32.size(); i++) begin
      total++;
      if (got32[i] !== exp32[i]) begin
        bad++;
        $display("FAIL random32[%0d]: got %h want %h", i, got32[i], exp32[i]);
      end
    end
    for (int i = 0; i < got64.size() && i < exp64.size(); i++) begin
      total++;
      if (got64[i] !== exp64[i]) begin
        bad++;
        $display("FAIL random64[%0d]: got %h want %h", i, got64[i], exp64[i]);
      end
    end
    $display("random: %0d results checked per width", got32.size());
  endtask

  task automatic test_backpressure();
    logic [2:0]  s[4];
    logic [23:0] ins[4];
    logic        c[4];
    int          sent = 0;
    int          stall_left = -1;
    logic        acc, stalled;
    logic [33:0] snap;
    for (int i = 0; i < 4; i++) begin
      s[i] = 3'($urandom_range(0, 4)); ins[i] = 24'($urandom); c[i] = 1'($urandom);
    end
    clear_q();
    for (int cyc = 0; cyc < 40 && (sent < 4 || got32.size() < 4); cyc++) begin
      b32.in_valid = (sent < 4);
      if (sent < 4) begin
        b32.imm_src = s[sent]; b32.instr = ins[sent]; b32.c_in = c[sent];
      end
      if (stall_left < 0 && b32.out_valid) stall_left = 3;
      b32.out_ready = !(stall_left > 0);
      @(negedge clk);
      acc = b32.in_valid && b32.in_ready;
      stalled = b32.out_valid && !b32.out_ready;
      snap = {b32.illegal, b32.c_out, b32.ext_imm};
      if (stall_left > 0) begin
        total++;
        if (b32.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, b32.in_ready);
        end
      end
      tick();
      if (acc) sent++;
      if (stalled) begin
        total++;
        if ({b32.illegal, b32.c_out, b32.ext_imm} !== snap) begin
          bad++;
          $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, {b32.illegal, b32.c_out, b32.ext_imm}, snap);
        end
      end
      if (stall_left > 0) stall_left--;
    end
    b32.in_valid = 0; b32.out_ready = 1;
    repeat (3) tick();
    total++;
    if (sent != 4 || got32.size() != 4 || exp32.size() != 4 || got64.size() != 4) begin
      bad++;
      $display("FAIL bp_count: got sent=%0d out=%0d out64=%0d want 4/4/4", sent, got32.size(), got64.size());
    end
    for (int i = 0; i < got32.size() && i < exp32.size(); i++) begin
      total++;
      if (got32[i] !== exp32[i]) begin
        bad++;
        $display("FAIL bp_order32[%0d]: got %h want %h", i, got32[i], exp32[i]);
      end
    end
    for (int i = 0; i < got64.size() && i < exp64.size(); i++) begin
      total++;
      if (got64[i] !== exp64[i]) begin
        bad++;
        $display("FAIL bp_order64[%0d]: got %h want %h", i, got64[i], exp64[i]);
      end
    end
    $display("backpressure: sent=%0d received=%0d", sent, got32.size());
  endtask

  task automatic test_flush();
    logic [65:0] want;
    b32.out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      b32.in_valid = 1; b32.imm_src = 3'($urandom_range(0, 4));
      b32.instr = 24'($urandom); b32.c_in = 1'($urandom);
      tick();
    end
    total++;
    if (b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_full: got out_valid=%b in_ready=%b want 1/0", b32.out_valid, b32.in_ready);
    end
    b32.flush = 1; b32.in_valid = 1; b32.imm_src = 3'd1; b32.instr = 24'h000ABC;
    tick();
    b32.flush = 0; b32.in_valid = 0;
    total++;
    if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear: got out_valid=%b/%b in_ready=%b want 0/0/1", b32.out_valid, b64.out_valid, b32.in_ready);
    end
    clear_q();
    b32.out_ready = 1;
    b32.in_valid = 1; b32.imm_src = 3'd3; b32.instr = 24'h000204; b32.c_in = 1'($urandom);
    want = model(32, b32.imm_src, b32.instr, b32.c_in);
    tick();
    b32.in_valid = 0;
    total++;
    if (b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_lat1: got out_valid=%b want 0", b32.out_valid);
    end
    tick();
    total++;
    if (b32.out_valid !== 1'b1 || {b32.illegal, b32.c_out, 32'h0, b32.ext_imm} !== want) begin
      bad++;
      $display("FAIL flush_lat2: got v=%b %h want v=1 %h", b32.out_valid, {b32.illegal, b32.c_out, 32'h0, b32.ext_imm}, want);
    end
    repeat (4) tick();
    total++;
    if (got32.size() != 1 || got64.size() != 1) begin
      bad++;
      $display("FAIL flush_leak: got %0d/%0d results want 1/1", got32.size(), got64.size());
    end
    $display("flush: post-flush results=%0d imm=%h", got32.size(), want[31:0]);
  endtask

  task automatic test_async_reset();
    b32.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      b32.in_valid = 1; b32.imm_src = 3'($urandom_range(0, 7));
      b32.instr = 24'($urandom) | 24'h1; b32.c_in = 1'($urandom);
      tick();
    end
    total++;
    if (b32.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre: got out_valid=%b want 1", b32.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (b32.out_valid !== 1'b0 || b32.ext_imm !== 32'h0 || b32.illegal !== 1'b0 || b32.c_out !== 1'b0) begin
      bad++;
      $display("FAIL areset32: got v=%b imm=%h ill=%b c=%b want all 0", b32.out_valid, b32.ext_imm, b32.illegal, b32.c_out);
    end
    total++;
    if (b64.out_valid !== 1'b0 || b64.ext_imm !== 64'h0 || b64.illegal !== 1'b0) begin
      bad++;
      $display("FAIL areset64: got v=%b imm=%h ill=%b want all 0", b64.out_valid, b64.ext_imm, b64.illegal);
    end
    b32.in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_q();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL areset_replay[%0d]: got out_valid=%b/%b want 0/0", i, b32.out_valid, b64.out_valid);
      end
    end
    $display("async reset: pending results after release=%0d", got32.size());
  endtask

  initial begin
    test_reset();
    test_modes();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
